// File: rtl/duty_ctrl_pkg.sv
// rtl/duty_ctrl_pkg.sv - shared types and default timing for the duty button front-end
package duty_ctrl_pkg;

  localparam int DUTY_W = 4;

  localparam int DEF_INITIAL_DUTY    = 5;
  localparam int DEF_DUTY_MAX        = 10;
  localparam int DEF_DEBOUNCE_CYCLES = 1000;
  localparam int DEF_REPEAT_DELAY    = 50000;
  localparam int DEF_REPEAT_PERIOD   = 20000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_REPEAT,
    ST_LOCK
  } state_t;

  typedef enum logic {
    DIR_INC,
    DIR_DEC
  } dir_t;

endpackage

// File: rtl/duty_ctrl_if.sv
// rtl/duty_ctrl_if.sv - button inputs and step/level outputs of duty_ctrl
// Ports (slave = duty_ctrl side):
//   inc_btn_in, dec_btn_in       raw buttons into duty_ctrl
//   increase_duty_out,
//   decrease_duty_out,
//   limit_hit_out                one-cycle pulses out of duty_ctrl
//   duty_level_out               shadow duty level out of duty_ctrl
interface duty_ctrl_if;
  import duty_ctrl_pkg::*;

  logic              inc_btn_in;
  logic              dec_btn_in;
  logic              increase_duty_out;
  logic              decrease_duty_out;
  logic              limit_hit_out;
  logic [DUTY_W-1:0] duty_level_out;

  modport slave (
    input  inc_btn_in, dec_btn_in,
    output increase_duty_out, decrease_duty_out, limit_hit_out, duty_level_out
  );

  modport master (
    output inc_btn_in, dec_btn_in,
    input  increase_duty_out, decrease_duty_out, limit_hit_out, duty_level_out
  );
endinterface

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - 2-flop synchroniser plus stable-count debouncer for one button
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   btn_in        raw asynchronous button
//   btn_db_out    debounced button level
module button_debounce
  import duty_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_db_out
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // The new level is accepted on the DEBOUNCE_CYCLES-th consecutive
  // disagreeing cycle; any agreeing cycle restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      cnt        <= '0;
      btn_db_out <= 1'b0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
      if (sync2 == btn_db_out) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        btn_db_out <= sync2;
        cnt        <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/duty_ctrl.sv
// rtl/duty_ctrl.sv - debounced button step scheduler with auto-repeat and saturating shadow duty
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   bus (slave)   raw buttons in; increase/decrease/limit pulses and duty level out
module duty_ctrl
  import duty_ctrl_pkg::*;
#(
  parameter int INITIAL_DUTY    = DEF_INITIAL_DUTY,
  parameter int DUTY_MAX        = DEF_DUTY_MAX,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input logic        clk,
  input logic        reset,
  duty_ctrl_if.slave bus
);

  localparam int TW = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
  localparam logic [TW-1:0]     DELAY_LAST  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0]     PERIOD_LAST = TW'(REPEAT_PERIOD - 1);
  localparam logic [DUTY_W-1:0] MAX_L       = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] INIT_L      = DUTY_W'(INITIAL_DUTY);

  logic inc_db;
  logic dec_db;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_db (
    .clk        (clk),
    .reset      (reset),
    .btn_in     (bus.inc_btn_in),
    .btn_db_out (inc_db)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec_db (
    .clk        (clk),
    .reset      (reset),
    .btn_in     (bus.dec_btn_in),
    .btn_db_out (dec_db)
  );

  state_t            state, state_n;
  dir_t              act, act_n;
  logic [TW-1:0]     timer, timer_n;
  logic [DUTY_W-1:0] duty_level, level_n;
  logic              inc_r, dec_r, lim_r;
  logic              inc_n, dec_n, lim_n;
  logic              do_step;
  dir_t              step_dir;
  logic              act_btn;
  logic              other_btn;

  assign act_btn   = (act == DIR_INC) ? inc_db : dec_db;
  assign other_btn = (act == DIR_INC) ? dec_db : inc_db;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      act        <= DIR_INC;
      timer      <= '0;
      duty_level <= INIT_L;
      inc_r      <= 1'b0;
      dec_r      <= 1'b0;
      lim_r      <= 1'b0;
    end else begin
      state      <= state_n;
      act        <= act_n;
      timer      <= timer_n;
      duty_level <= level_n;
      inc_r      <= inc_n;
      dec_r      <= dec_n;
      lim_r      <= lim_n;
    end
  end

  always_comb begin
    state_n  = state;
    act_n    = act;
    timer_n  = timer;
    do_step  = 1'b0;
    step_dir = act;

    case (state)
      ST_IDLE: begin
        timer_n = '0;
        if (inc_db && dec_db) begin
          state_n = ST_LOCK;
        end else if (inc_db) begin
          do_step  = 1'b1;
          step_dir = DIR_INC;
          act_n    = DIR_INC;
          state_n  = ST_HOLD;
        end else if (dec_db) begin
          do_step  = 1'b1;
          step_dir = DIR_DEC;
          act_n    = DIR_DEC;
          state_n  = ST_HOLD;
        end
      end
      ST_HOLD, ST_REPEAT: begin
        // Priority order makes release and conflict beat a same-cycle expiry.
        if (!act_btn) begin
          state_n = ST_IDLE;
          timer_n = '0;
        end else if (other_btn) begin
          state_n = ST_LOCK;
          timer_n = '0;
        end else if (timer == ((state == ST_HOLD) ? DELAY_LAST : PERIOD_LAST)) begin
          do_step = 1'b1;
          state_n = ST_REPEAT;
          timer_n = '0;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      ST_LOCK: begin
        timer_n = '0;
        if (!inc_db && !dec_db) state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
        timer_n = '0;
      end
    endcase

    // A step either moves the shadow level and pulses the matching output,
    // or is swallowed at the rail and reported on the limit pulse.
    inc_n   = 1'b0;
    dec_n   = 1'b0;
    lim_n   = 1'b0;
    level_n = duty_level;
    if (do_step) begin
      if (step_dir == DIR_INC) begin
        if (duty_level < MAX_L) begin
          inc_n   = 1'b1;
          level_n = duty_level + DUTY_W'(1);
        end else begin
          lim_n = 1'b1;
        end
      end else begin
        if (duty_level != '0) begin
          dec_n   = 1'b1;
          level_n = duty_level - DUTY_W'(1);
        end else begin
          lim_n = 1'b1;
        end
      end
    end
  end

  assign bus.increase_duty_out = inc_r;
  assign bus.decrease_duty_out = dec_r;
  assign bus.limit_hit_out     = lim_r;
  assign bus.duty_level_out    = duty_level;

endmodule

// File: tb/tb_duty_ctrl.sv
// tb/tb_duty_ctrl.sv - directed self-checking bench for duty_ctrl
module tb_duty_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  duty_ctrl_if bus ();

  duty_ctrl #(
    .INITIAL_DUTY    (5),
    .DUTY_MAX        (10),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int inc_q[$];
  int dec_q[$];
  int lim_q[$];

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int q_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Entered at a falling edge. Buttons are driven for cycle c at the falling
  // edge that opens it; pulses are recorded at the falling edge after the
  // c-th rising edge, so a step seen there belongs to cycle c.
  task automatic run_seq(input int inc_on, input int inc_off,
                         input int dec_on, input int dec_off, input int total);
    inc_q.delete();
    dec_q.delete();
    lim_q.delete();
    for (int c = 0; c < total; c++) begin
      if (c > 0) begin
        @(posedge clk);
        @(negedge clk);
        if (bus.increase_duty_out) inc_q.push_back(c);
        if (bus.decrease_duty_out) dec_q.push_back(c);
        if (bus.limit_hit_out)     lim_q.push_back(c);
        check("exclusive",
              int'(bus.increase_duty_out) + int'(bus.decrease_duty_out) + int'(bus.limit_hit_out) > 1,
              0);
      end
      bus.inc_btn_in = (c >= inc_on) && (c < inc_off);
      bus.dec_btn_in = (c >= dec_on) && (c < dec_off);
    end
  endtask

  initial begin
    bus.inc_btn_in = 1'b0;
    bus.dec_btn_in = 1'b0;

    #2 reset = 1'b1;
    #1;
    check("rst_level", int'(bus.duty_level_out), 5);
    check("rst_inc", int'(bus.increase_duty_out), 0);
    check("rst_dec", int'(bus.decrease_duty_out), 0);
    check("rst_lim", int'(bus.limit_hit_out), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // single press, 8 cycles
    run_seq(0, 8, -1, -1, 20);
    check("single_n", inc_q.size(), 1);
    check("single_t", q_at(inc_q, 0), 7);
    check("single_dec", dec_q.size() + lim_q.size(), 0);
    check("single_level", int'(bus.duty_level_out), 6);

    // 3-cycle glitch on dec
    run_seq(-1, -1, 0, 3, 12);
    check("glitch_n", inc_q.size() + dec_q.size() + lim_q.size(), 0);
    check("glitch_level", int'(bus.duty_level_out), 6);

    // long inc hold: auto-repeat up to the ceiling, then limit pulses
    run_seq(0, 60, -1, -1, 75);
    check("rep_inc_n", inc_q.size(), 4);
    check("rep_inc0", q_at(inc_q, 0), 7);
    check("rep_inc1", q_at(inc_q, 1), 17);
    check("rep_inc2", q_at(inc_q, 2), 20);
    check("rep_inc3", q_at(inc_q, 3), 23);
    check("rep_lim0", q_at(lim_q, 0), 26);
    check("rep_lim1", q_at(lim_q, 1), 29);
    check("rep_lim_n", lim_q.size(), 14);
    check("rep_lim_last", q_at(lim_q, 13), 65);
    check("rep_dec_n", dec_q.size(), 0);
    check("rep_level", int'(bus.duty_level_out), 10);

    // conflict: inc debounces on the same edge the HOLD timer would expire
    run_seq(10, 40, 0, 40, 55);
    check("conf_dec_n", dec_q.size(), 1);
    check("conf_dec_t", q_at(dec_q, 0), 7);
    check("conf_other", inc_q.size() + lim_q.size(), 0);
    check("conf_level", int'(bus.duty_level_out), 9);
    run_seq(-1, -1, 0, 8, 20);
    check("post_lock_n", dec_q.size(), 1);
    check("post_lock_t", q_at(dec_q, 0), 7);
    check("post_lock_level", int'(bus.duty_level_out), 8);

    // back to the initial level, then walk down to the floor
    reset = 1'b1;
    #1;
    check("rst2_level", int'(bus.duty_level_out), 5);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      run_seq(-1, -1, 0, 8, 20);
      check("floor_dec_t", q_at(dec_q, 0), 7);
      check("floor_n", dec_q.size() + inc_q.size() + lim_q.size(), 1);
      check("floor_level", int'(bus.duty_level_out), 4 - i);
    end
    run_seq(-1, -1, 0, 8, 20);
    check("floor_lim_t", q_at(lim_q, 0), 7);
    check("floor_lim_n", lim_q.size(), 1);
    check("floor_lim_dec", dec_q.size(), 0);
    check("floor_lim_level", int'(bus.duty_level_out), 0);

    // asynchronous reset during REPEAT while a pulse is on the output
    run_seq(0, 1000, -1, -1, 21);
    check("ar_inc_n", inc_q.size(), 3);
    check("ar_inc_t", q_at(inc_q, 2), 20);
    check("ar_pulse_before", int'(bus.increase_duty_out), 1);
    check("ar_level_before", int'(bus.duty_level_out), 3);
    #2 reset = 1'b1;
    #1;
    check("ar_pulse_clear", int'(bus.increase_duty_out), 0);
    check("ar_level_clear", int'(bus.duty_level_out), 5);
    @(negedge clk);
    @(negedge clk);
    check("ar_hold_pulse", int'(bus.increase_duty_out) + int'(bus.limit_hit_out), 0);
    reset = 1'b0;
    run_seq(0, 8, -1, -1, 20);
    check("ar_after_n", inc_q.size(), 1);
    check("ar_after_t", q_at(inc_q, 0), 7);
    check("ar_after_level", int'(bus.duty_level_out), 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
